dac_channel_mixer: RTL and testbench

//  Time-multiplexed sound mixer and scheduler for the board's single sigma-delta DAC.

---
 rtl/sound_pkg.sv | 22 ++
 rtl/dac_channel_mixer_if.sv | 33 +++
 rtl/sample_tick_gen.sv | 31 +++
 rtl/dac_channel_mixer.sv | 147 ++++++++++++++
 tb/tb_dac_channel_mixer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound subsystem: mixer FSM states, attenuation
// field width and the accumulator sizing rule.
package sound_pkg;

  // Width of one channel's attenuation (right-shift) field.
  localparam int ATT_W = 2;

  // Mixer sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    OUT
  } mix_state_e;

  // Accumulator width: one signed sample is MSBI+1 bits. One guard bit plus
  // clog2(nch) growth bits let the sum of nch samples never wrap.
  function automatic int acc_width(input int msbi, input int nch);
    return msbi + 2 + $clog2(nch);
  endfunction

endpackage

// File: rtl/dac_channel_mixer_if.sv
// Per-channel sample handshake bus between the sample sources and the mixer.
// Channel i occupies bit i of the scalar vectors and its own slice of the
// data and attenuation vectors.
interface dac_channel_mixer_if #(
  parameter int NCH  = 4,
  parameter int MSBI = 7
);

  logic [NCH-1:0]                   ch_enable;
  logic [NCH-1:0]                   ch_valid;
  logic [NCH*(MSBI+1)-1:0]          ch_data;
  logic [sound_pkg::ATT_W*NCH-1:0]  ch_att;
  logic [NCH-1:0]                   ch_ready;

  // Sample sources drive the samples and take the accept pulse.
  modport master (
    output ch_enable,
    output ch_valid,
    output ch_data,
    output ch_att,
    input  ch_ready
  );

  // The mixer takes the samples and drives the accept pulse.
  modport slave (
    input  ch_enable,
    input  ch_valid,
    input  ch_data,
    input  ch_att,
    output ch_ready
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Output sample-rate prescaler: a free-running counter 0..DIV-1 that raises
// tick for the single cycle in which it holds DIV-1.
module sample_tick_gen #(
  parameter int DIV = 256
) (
  input  logic CLK,
  input  logic RESET,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running period counter, wrapping after DIV-1.
  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dac_channel_mixer.sv
// Time-multiplexed mixer for the sigma-delta DAC. Each sample period it visits
// every channel once through a single shared adder, attenuates and sums the
// accepted samples, saturates the total and presents it as one excess-2**MSBI
// word with a one-cycle strobe.
module dac_channel_mixer
  import sound_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MSBI = 7,
  parameter int DIV  = 256
) (
  input  logic                CLK,
  input  logic                RESET,
  dac_channel_mixer_if.slave  ch,
  input  logic                clr_flags,
  output logic [MSBI:0]       dac_data,
  output logic                dac_strobe,
  output logic [NCH-1:0]      underrun,
  output logic                clip
);

  localparam int W     = MSBI + 1;
  localparam int ACC_W = acc_width(MSBI, NCH);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NCH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2**MSBI - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2**MSBI));
  localparam logic [MSBI:0]           MIDSCALE = {1'b1, {MSBI{1'b0}}};

  logic tick;

  mix_state_e                state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic                      last_slot;
  logic [MSBI:0]             sel_data;
  logic [ATT_W-1:0]          sel_att;
  logic                      sel_take;
  logic signed [MSBI:0]      centered;
  logic signed [MSBI:0]      shifted;
  logic signed [ACC_W-1:0]   contrib;
  logic [NCH-1:0]            ur_set;
  logic                      over, under;
  logic [MSBI:0]             sat_word;

  sample_tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .tick  (tick)
  );

  assign last_slot = (idx_q == LAST_IDX);

  // Current slot's sample, converted from excess-2**MSBI to two's complement
  // by inverting the MSB, then attenuated and sign-extended to the adder width.
  assign sel_data = ch.ch_data[int'(idx_q)*W +: W];
  assign sel_att  = ch.ch_att[int'(idx_q)*ATT_W +: ATT_W];
  assign sel_take = ch.ch_enable[idx_q] & ch.ch_valid[idx_q];
  assign centered = {~sel_data[MSBI], sel_data[MSBI-1:0]};
  assign shifted  = centered >>> sel_att;
  assign contrib  = {{(ACC_W-W){shifted[MSBI]}}, shifted};

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, per-slot accept pulse and underrun detection.
  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    ch.ch_ready = '0;
    ur_set      = '0;
    case (state_q)
      IDLE: begin
        if (tick) state_d = ACCUM;
      end
      ACCUM: begin
        ch.ch_ready[idx_q] = ch.ch_enable[idx_q];
        ur_set[idx_q]      = ch.ch_enable[idx_q] & ~ch.ch_valid[idx_q];
        if (last_slot) state_d = SAT;
      end
      SAT:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slot index and running sum; restarted on each sample tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            idx_q <= '0;
            acc_q <= '0;
          end
        end
        ACCUM: begin
          if (sel_take) acc_q <= acc_q + contrib;
          if (!last_slot) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Clamp the sum to the DAC range and convert back to excess-2**MSBI.
  always_comb begin
    over  = (acc_q > SAT_MAX);
    under = (acc_q < SAT_MIN);
    if (over) begin
      sat_word = {(MSBI+1){1'b1}};
    end else if (under) begin
      sat_word = '0;
    end else begin
      sat_word = {~acc_q[MSBI], acc_q[MSBI-1:0]};
    end
  end

  // Output word (loaded as OUT is entered, so it is new during the strobe)
  // and sticky flags, where a set in the same cycle beats a clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dac_data <= MIDSCALE;
      underrun <= '0;
      clip     <= 1'b0;
    end else begin
      if (state_q == SAT) dac_data <= sat_word;
      underrun <= (clr_flags ? '0 : underrun) | ur_set;
      clip     <= (clr_flags ? 1'b0 : clip) | ((state_q == SAT) & (over | under));
    end
  end

  assign dac_strobe = (state_q == OUT);

endmodule

// File: tb/tb_dac_channel_mixer.sv
// Self-checking bench for dac_channel_mixer: directed cases for the documented
// examples followed by randomized frames, all compared cycle by cycle against
// an arithmetic reference model of the mixer's behaviour.
module tb_dac_channel_mixer;

  localparam int NCH  = 4;
  localparam int MSBI = 7;
  localparam int DIV  = 16;

  logic           CLK;
  logic           RESET;
  logic           clr_flags;
  logic [MSBI:0]  dac_data;
  logic           dac_strobe;
  logic [NCH-1:0] underrun;
  logic           clip;

  dac_channel_mixer_if #(.NCH(NCH), .MSBI(MSBI)) ch_if ();

  dac_channel_mixer #(.NCH(NCH), .MSBI(MSBI), .DIV(DIV)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ch         (ch_if.slave),
    .clr_flags  (clr_flags),
    .dac_data   (dac_data),
    .dac_strobe (dac_strobe),
    .underrun   (underrun),
    .clip       (clip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stimulus held per channel; packed onto the bus by drive().
  logic [NCH-1:0] en, vl;
  logic [MSBI:0]  dat   [NCH];
  logic [1:0]     att_a [NCH];

  // Reference model state.
  int             cyc;      // cycles since reset release == prescaler count mod DIV
  logic [MSBI:0]  m_dac;
  logic [NCH-1:0] m_ur;
  logic           m_clip;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    ch_if.ch_enable = en;
    ch_if.ch_valid  = vl;
    for (int i = 0; i < NCH; i++) begin
      ch_if.ch_data[i*(MSBI+1) +: (MSBI+1)] = dat[i];
      ch_if.ch_att[2*i +: 2]                = att_a[i];
    end
  endtask

  task automatic set_all(input logic [NCH-1:0] e, input logic [NCH-1:0] v,
                         input logic [MSBI:0] d, input logic [1:0] a);
    en = e;
    vl = v;
    for (int i = 0; i < NCH; i++) begin
      dat[i]   = d;
      att_a[i] = a;
    end
    drive();
  endtask

  // Sum of attenuated signed samples of all accepted channels; the right
  // shift is modelled as floor division by a power of two.
  function automatic int mix_sum();
    int s;
    s = 0;
    for (int i = 0; i < NCH; i++) begin
      if (en[i] && vl[i]) begin
        int v, d;
        v = int'(dat[i]) - 128;
        d = 1 << att_a[i];
        if (v >= 0) s += v / d;
        else        s -= (-v + d - 1) / d;
      end
    end
    return s;
  endfunction

  // Advance one clock, update the model with what this cycle commits, then
  // compare all outputs 1 time unit after the edge.
  task automatic step();
    int ph, s, ph2;
    logic [NCH-1:0] exp_ready;
    logic [NCH-1:0] set_ur;
    logic set_clip, exp_strobe;
    ph = cyc % DIV;
    set_ur = '0;
    set_clip = 1'b0;
    if (RESET) begin
      m_dac  = 8'h80;
      m_ur   = '0;
      m_clip = 1'b0;
    end else begin
      if (cyc >= DIV && ph < NCH && en[ph] && !vl[ph]) set_ur[ph] = 1'b1;
      if (cyc >= DIV && ph == NCH) begin
        s = mix_sum();
        set_clip = (s > 127) || (s < -128);
        if (s > 127)       m_dac = 8'hFF;
        else if (s < -128) m_dac = 8'h00;
        else               m_dac = 8'(s + 128);
      end
      m_ur   = (clr_flags ? '0 : m_ur) | set_ur;
      m_clip = (clr_flags ? 1'b0 : m_clip) | set_clip;
    end
    @(posedge CLK);
    #1;
    if (!RESET) cyc++;
    ph2 = cyc % DIV;
    exp_ready  = '0;
    exp_strobe = 1'b0;
    if (!RESET && cyc >= DIV) begin
      if (ph2 < NCH && en[ph2]) exp_ready[ph2] = 1'b1;
      exp_strobe = (ph2 == NCH + 1);
    end
    check("ch_ready",   32'(ch_if.ch_ready), 32'(exp_ready));
    check("dac_strobe", 32'(dac_strobe),     32'(exp_strobe));
    check("dac_data",   32'(dac_data),       32'(m_dac));
    check("underrun",   32'(underrun),       32'(m_ur));
    check("clip",       32'(clip),           32'(m_clip));
  endtask

  // Step until the strobe cycle of the next frame; optional random clears.
  task automatic run_frame(input bit rand_clr);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2*DIV + 8 && !done; k++) begin
      clr_flags = rand_clr ? ($urandom_range(0, 5) == 0) : 1'b0;
      step();
      if (cyc >= DIV && (cyc % DIV) == NCH + 1) done = 1'b1;
    end
    clr_flags = 1'b0;
    if (!done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    clr_flags = 1'b0;
    cyc       = 0;
    m_dac     = 8'h80;
    m_ur      = '0;
    m_clip    = 1'b0;
    set_all('0, '0, 8'h80, 2'd0);

    // 1. Reset held with no stimulus, then one silent frame.
    for (int i = 0; i < 3; i++) step();
    RESET = 1'b0;
    cyc   = 0;
    run_frame(1'b0);
    check("t1_dac", 32'(dac_data), 32'h80);

    // 2. Single channel, no attenuation.
    set_all(4'b0001, 4'b1111, 8'h80, 2'd0);
    dat[0] = 8'hC0;
    drive();
    run_frame(1'b0);
    check("t2_dac", 32'(dac_data), 32'hC0);

    // 3. Two channels summed.
    en = 4'b0011;
    dat[1] = 8'hA0;
    drive();
    run_frame(1'b0);
    check("t3_dac", 32'(dac_data), 32'hE0);

    // 4. Negative full scale attenuated by 4.
    set_all(4'b0001, 4'b1111, 8'h80, 2'd0);
    dat[0]   = 8'h00;
    att_a[0] = 2'd2;
    drive();
    run_frame(1'b0);
    check("t4_dac", 32'(dac_data), 32'h60);

    // 5. Positive then negative saturation with a clear in between.
    set_all(4'b1111, 4'b1111, 8'hFF, 2'd0);
    run_frame(1'b0);
    check("t5_dac_hi",  32'(dac_data), 32'hFF);
    check("t5_clip_hi", 32'(clip),     32'h1);
    pulse_clr();
    check("t5_clip_clr", 32'(clip), 32'h0);
    set_all(4'b1111, 4'b1111, 8'h00, 2'd0);
    run_frame(1'b0);
    check("t5_dac_lo",  32'(dac_data), 32'h00);
    check("t5_clip_lo", 32'(clip),     32'h1);
    pulse_clr();

    // 6a. Underrun on ch2 contributes nothing to the mix.
    set_all(4'b0101, 4'b0001, 8'h80, 2'd0);
    dat[0] = 8'hC0;
    dat[2] = 8'hFF;
    drive();
    run_frame(1'b0);
    check("t6_ur",  32'(underrun), 32'h4);
    check("t6_dac", 32'(dac_data), 32'hC0);

    // 6b. Clear coincident with ch2's slot: the set wins.
    while ((cyc % DIV) != 2) step();
    pulse_clr();
    run_frame(1'b0);
    check("t6_ur_setwins", 32'(underrun), 32'h4);

    // 6c. Reset asserted mid-accumulation.
    while ((cyc % DIV) != 1) step();
    RESET = 1'b1;
    #1;
    check("t6_rst_dac",    32'(dac_data),   32'h80);
    check("t6_rst_strobe", 32'(dac_strobe), 32'h0);
    check("t6_rst_ur",     32'(underrun),   32'h0);
    m_dac  = 8'h80;
    m_ur   = '0;
    m_clip = 1'b0;
    cyc    = 0;
    for (int i = 0; i < 2; i++) step();
    RESET = 1'b0;
    run_frame(1'b0);

    // Randomized frames with occasional flag clears.
    for (int f = 0; f < 30; f++) begin
      en = NCH'($urandom);
      vl = NCH'($urandom) | NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 3))
          0:       dat[i] = 8'hFF;
          1:       dat[i] = 8'h00;
          default: dat[i] = 8'($urandom);
        endcase
        att_a[i] = 2'($urandom);
      end
      drive();
      run_frame(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
